fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the decode/execute logic inside `computer`.
- Maintains the fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers up to 2 fetched instructions in a prefetch FIFO and presents them to decode with a valid/ready handshake.
- Accepts branch/jump redirects from execute, flushing the FIFO and any wrong-path data.

---
 rtl/fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_fetch_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage with a 2-entry prefetch FIFO and
//               branch redirect; optional FETCH_PERF_EN adds perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int             AW       = 16,
    parameter int             DW       = 16,
    parameter logic [AW-1:0]  RESET_PC = 16'h0000
) (
    input  logic          clock_50_b7a,
    input  logic          cpu_reset_n,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    input  logic          halt,
    output logic          ir_valid,
    output logic [DW-1:0] ir_data,
    output logic [AW-1:0] ir_pc,
    input  logic          ir_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   perf_starve_cnt,
    output logic [15:0]   perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_n;
    logic [AW-1:0] r_fetch_pc;
    logic [AW-1:0] w_fetch_pc_n;
    logic [1:0]    r_count;
    logic [1:0]    w_count_n;
    logic          r_rptr;
    logic          r_wptr;
    logic [DW-1:0] r_fifo_data [2];
    logic [AW-1:0] r_fifo_pc   [2];
    logic [DW-1:0] r_ir_data;
    logic [AW-1:0] r_ir_pc;
    logic          r_mem_req;
    logic [AW-1:0] r_mem_addr;
    logic          w_push;
    logic          w_pop;
    logic          w_issue;

    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
    assign ir_valid = (r_count != 2'd0);
    assign ir_data  = r_ir_data;
    assign ir_pc    = r_ir_pc;

    always_ff @(posedge clock_50_b7a or negedge cpu_reset_n) begin
        if (!cpu_reset_n) r_state <= S_IDLE;
        else              r_state <= w_state_n;
    end

    // Redirect outranks everything: it kills the push, the pop and any issue.
    always_comb begin
        w_state_n    = r_state;
        w_issue      = 1'b0;
        w_push       = (r_state == S_REQ) && mem_ack && !redirect;
        w_pop        = (r_count != 2'd0) && ir_ready && !redirect;
        w_count_n    = redirect ? 2'd0
                                : (r_count + {1'b0, w_push} - {1'b0, w_pop});
        w_fetch_pc_n = redirect ? redirect_pc
                                : (w_push ? (r_fetch_pc + 1'b1) : r_fetch_pc);
        case (r_state)
            S_IDLE: begin
                if (!halt && (r_count < 2'd2) && !redirect) begin
                    w_state_n = S_REQ;
                    w_issue   = 1'b1;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    if (!redirect && !halt && (w_count_n < 2'd2)) begin
                        w_state_n = S_REQ;
                        w_issue   = 1'b1;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end else if (redirect) begin
                    w_state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (mem_ack) w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_50_b7a or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            r_fetch_pc <= RESET_PC;
            r_count    <= 2'd0;
            r_rptr     <= 1'b0;
            r_wptr     <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= RESET_PC;
            r_ir_data  <= '0;
            r_ir_pc    <= '0;
        end else begin
            r_fetch_pc <= w_fetch_pc_n;
            r_count    <= w_count_n;
            r_mem_req  <= (w_state_n != S_IDLE);
            if (w_issue) r_mem_addr <= w_fetch_pc_n;
            if (redirect) begin
                r_rptr <= 1'b0;
                r_wptr <= 1'b0;
            end else begin
                if (w_push) r_wptr <= ~r_wptr;
                if (w_pop)  r_rptr <= ~r_rptr;
                // Head register tracks the next head; it holds when the FIFO empties.
                if (w_pop && (r_count == 2'd2)) begin
                    r_ir_data <= r_fifo_data[~r_rptr];
                    r_ir_pc   <= r_fifo_pc[~r_rptr];
                end else if (w_push && ((r_count == 2'd0) || w_pop)) begin
                    r_ir_data <= mem_rdata;
                    r_ir_pc   <= r_fetch_pc;
                end
            end
        end
    end

    always_ff @(posedge clock_50_b7a) begin
        if (w_push) begin
            r_fifo_data[r_wptr] <= mem_rdata;
            r_fifo_pc[r_wptr]   <= r_fetch_pc;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_starve_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clock_50_b7a or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            r_starve_cnt <= 32'd0;
            r_flush_cnt  <= 16'd0;
        end else begin
            if (!ir_valid && !halt) r_starve_cnt <= r_starve_cnt + 32'd1;
            if (redirect)           r_flush_cnt  <= r_flush_cnt + 16'd1;
        end
    end

    assign perf_starve_cnt = r_starve_cnt;
    assign perf_flush_cnt  = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit (two instances:
//               RESET_PC=0 and RESET_PC=16'hFFFE).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n, rst2_n;
    logic        mem_req, mem_ack, mem_req2;
    logic [15:0] mem_addr, mem_rdata, mem_addr2;
    logic        redirect, halt, ir_ready;
    logic [15:0] redirect_pc;
    logic        ir_valid, ir_valid2;
    logic [15:0] ir_data, ir_pc, ir_data2, ir_pc2;
    logic        ack_mode, man_ack;
    logic [15:0] man_rdata;
    int          n_pass  = 0;
    int          n_total = 0;

`ifdef FETCH_PERF_EN
    logic [31:0] starve_cnt, starve_cnt2;
    logic [15:0] flush_cnt, flush_cnt2;
`endif

    always #5 clk = ~clk;

    // ack_mode=1: zero-wait memory returning addr^16'hA5A5; ack_mode=0: driven by the steps.
    assign mem_ack   = ack_mode ? mem_req : man_ack;
    assign mem_rdata = ack_mode ? (mem_addr ^ 16'hA5A5) : man_rdata;

    fetch_unit #(.AW(16), .DW(16), .RESET_PC(16'h0000)) dut (
        .clock_50_b7a (clk),
        .cpu_reset_n  (rst_n),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .halt         (halt),
        .ir_valid     (ir_valid),
        .ir_data      (ir_data),
        .ir_pc        (ir_pc),
        .ir_ready     (ir_ready)
`ifdef FETCH_PERF_EN
        ,
        .perf_starve_cnt (starve_cnt),
        .perf_flush_cnt  (flush_cnt)
`endif
    );

    fetch_unit #(.AW(16), .DW(16), .RESET_PC(16'hFFFE)) dut2 (
        .clock_50_b7a (clk),
        .cpu_reset_n  (rst2_n),
        .mem_req      (mem_req2),
        .mem_addr     (mem_addr2),
        .mem_ack      (mem_req2),
        .mem_rdata    (mem_addr2 ^ 16'hA5A5),
        .redirect     (1'b0),
        .redirect_pc  (16'h0000),
        .halt         (1'b0),
        .ir_valid     (ir_valid2),
        .ir_data      (ir_data2),
        .ir_pc        (ir_pc2),
        .ir_ready     (1'b1)
`ifdef FETCH_PERF_EN
        ,
        .perf_starve_cnt (starve_cnt2),
        .perf_flush_cnt  (flush_cnt2)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0;
        ack_mode = 1'b1; man_ack = 1'b0; man_rdata = 16'h0000;
        redirect = 1'b0; redirect_pc = 16'h0000; halt = 1'b0; ir_ready = 1'b1;
        tick(); tick();
        chk("rst_mem_req",  {31'd0, mem_req},  32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'h0000);
        chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_ir_data",  {16'd0, ir_data},  32'h0000);
        chk("rst_ir_pc",    {16'd0, ir_pc},    32'h0000);
        chk("rst2_mem_addr", {16'd0, mem_addr2}, 32'hFFFE);

        // Streaming: zero-wait memory, decode always ready
        rst_n = 1'b1; rst2_n = 1'b1;
        tick();
        chk("s1_req",      {31'd0, mem_req},  32'd1);
        chk("s1_addr",     {16'd0, mem_addr}, 32'h0000);
        chk("s1_valid",    {31'd0, ir_valid}, 32'd0);
        chk("s1_addr2",    {16'd0, mem_addr2}, 32'hFFFE);
        tick();
        chk("s2_addr",     {16'd0, mem_addr}, 32'h0001);
        chk("s2_valid",    {31'd0, ir_valid}, 32'd1);
        chk("s2_pc",       {16'd0, ir_pc},    32'h0000);
        chk("s2_data",     {16'd0, ir_data},  32'hA5A5);
        chk("s2_pc2",      {16'd0, ir_pc2},   32'hFFFE);
        chk("s2_data2",    {16'd0, ir_data2}, 32'h5A5B);
        tick();
        chk("s3_addr",     {16'd0, mem_addr}, 32'h0002);
        chk("s3_pc",       {16'd0, ir_pc},    32'h0001);
        chk("s3_data",     {16'd0, ir_data},  32'hA5A4);
        chk("s3_pc2",      {16'd0, ir_pc2},   32'hFFFF);
        tick();
        chk("s4_addr",     {16'd0, mem_addr}, 32'h0003);
        chk("s4_pc",       {16'd0, ir_pc},    32'h0002);
        chk("s4_data",     {16'd0, ir_data},  32'hA5A7);
        chk("s4_pc2",      {16'd0, ir_pc2},   32'h0000);
        tick();
        chk("s5_pc",       {16'd0, ir_pc},    32'h0003);
        chk("s5_data",     {16'd0, ir_data},  32'hA5A6);
        chk("s5_pc2",      {16'd0, ir_pc2},   32'h0001);
        chk("s5_data2",    {16'd0, ir_data2}, 32'hA5A4);

        // Back-pressure: decode stalled, FIFO fills after two acks
        rst_n = 1'b0; ir_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("bp1_req",     {31'd0, mem_req},  32'd1);
        chk("bp1_addr",    {16'd0, mem_addr}, 32'h0000);
        tick();
        chk("bp2_req",     {31'd0, mem_req},  32'd1);
        chk("bp2_addr",    {16'd0, mem_addr}, 32'h0001);
        tick();
        chk("bp3_req",     {31'd0, mem_req},  32'd0);
        chk("bp3_valid",   {31'd0, ir_valid}, 32'd1);
        chk("bp3_pc",      {16'd0, ir_pc},    32'h0000);
        tick();
        chk("bp4_req",     {31'd0, mem_req},  32'd0);
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        chk("bp5_pc",      {16'd0, ir_pc},    32'h0001);
        chk("bp5_data",    {16'd0, ir_data},  32'hA5A4);
        chk("bp5_req",     {31'd0, mem_req},  32'd0);
        tick();
        chk("bp6_req",     {31'd0, mem_req},  32'd1);
        chk("bp6_addr",    {16'd0, mem_addr}, 32'h0002);
        chk("bp6_pc",      {16'd0, ir_pc},    32'h0001);

        // Redirect during a slow (3-cycle) request: wrong-path data dropped
        rst_n = 1'b0; ack_mode = 1'b0; man_ack = 1'b0; ir_ready = 1'b1;
        tick();
        rst_n = 1'b1; redirect = 1'b1; redirect_pc = 16'h0005;
        tick();
        redirect = 1'b0;
        chk("rd0_req",     {31'd0, mem_req},  32'd0);
        tick();
        chk("rd1_req",     {31'd0, mem_req},  32'd1);
        chk("rd1_addr",    {16'd0, mem_addr}, 32'h0005);
        tick();
        redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        chk("rd3_req",     {31'd0, mem_req},  32'd1);
        chk("rd3_addr",    {16'd0, mem_addr}, 32'h0005);
        man_ack = 1'b1; man_rdata = 16'hBEEF;
        tick();
        man_ack = 1'b0;
        chk("rd4_req",     {31'd0, mem_req},  32'd0);
        chk("rd4_valid",   {31'd0, ir_valid}, 32'd0);
        tick();
        chk("rd5_req",     {31'd0, mem_req},  32'd1);
        chk("rd5_addr",    {16'd0, mem_addr}, 32'h0040);
        man_ack = 1'b1; man_rdata = 16'h1234;
        tick();
        chk("rd6_valid",   {31'd0, ir_valid}, 32'd1);
        chk("rd6_pc",      {16'd0, ir_pc},    32'h0040);
        chk("rd6_data",    {16'd0, ir_data},  32'h1234);
        chk("rd6_addr",    {16'd0, mem_addr}, 32'h0041);

        // Redirect coincident with ack and a pop attempt (count=1)
        redirect = 1'b1; redirect_pc = 16'h0080; man_ack = 1'b1; man_rdata = 16'h5555;
        tick();
        redirect = 1'b0; man_ack = 1'b0;
        chk("rc0_valid",   {31'd0, ir_valid}, 32'd0);
        chk("rc0_req",     {31'd0, mem_req},  32'd0);
        chk("rc0_pc_hold", {16'd0, ir_pc},    32'h0040);
        tick();
        chk("rc1_req",     {31'd0, mem_req},  32'd1);
        chk("rc1_addr",    {16'd0, mem_addr}, 32'h0080);
        man_ack = 1'b1; man_rdata = 16'h7777;
        tick();
        chk("rc2_pc",      {16'd0, ir_pc},    32'h0080);
        chk("rc2_data",    {16'd0, ir_data},  32'h7777);
        chk("rc2_addr",    {16'd0, mem_addr}, 32'h0081);

        // halt with a request outstanding: its ack still pushes, nothing new issued
        halt = 1'b1; ir_ready = 1'b0; man_ack = 1'b1; man_rdata = 16'h9999;
        tick();
        man_ack = 1'b0;
        chk("h0_req",      {31'd0, mem_req},  32'd0);
        chk("h0_pc",       {16'd0, ir_pc},    32'h0080);
        ir_ready = 1'b1;
        tick();
        chk("h1_pc",       {16'd0, ir_pc},    32'h0081);
        chk("h1_data",     {16'd0, ir_data},  32'h9999);
        chk("h1_req",      {31'd0, mem_req},  32'd0);
        tick();
        chk("h2_valid",    {31'd0, ir_valid}, 32'd0);
        chk("h2_pc_hold",  {16'd0, ir_pc},    32'h0081);
        chk("h2_req",      {31'd0, mem_req},  32'd0);
        halt = 1'b0;
        tick();
        chk("h3_req",      {31'd0, mem_req},  32'd1);
        chk("h3_addr",     {16'd0, mem_addr}, 32'h0082);
        man_ack = 1'b1; man_rdata = 16'hAAAA;
        tick();
        chk("h4_valid",    {31'd0, ir_valid}, 32'd1);

        // Asynchronous reset mid-request, then a late ack in IDLE
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_req",      {31'd0, mem_req},  32'd0);
        chk("ar_valid",    {31'd0, ir_valid}, 32'd0);
        chk("ar_addr",     {16'd0, mem_addr}, 32'h0000);
        tick();
        rst_n = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("ar1_valid",   {31'd0, ir_valid}, 32'd0);
        chk("ar1_req",     {31'd0, mem_req},  32'd1);
        chk("ar1_addr",    {16'd0, mem_addr}, 32'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
